// File: rtl/pi_link_pkg.sv
// pi_link_pkg
// Shared definitions for the Raspberry Pi parallel byte link:
//   pi_state_e - receiver handshake FSM states
//   PI_DATA_W  - width of the Pi data bus
//   RX_CNT_W   - width of the accepted-byte counter
package pi_link_pkg;

    localparam int PI_DATA_W = 8;
    localparam int RX_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_ACK     = 2'd2,
        ST_RECOVER = 2'd3
    } pi_state_e;

endpackage

// File: rtl/pi_byte_receiver_if.sv
// pi_byte_receiver_if
// Bundles the Pi-facing 4-phase link and the downstream byte stream.
//   pi_req_raw  Pi -> FPGA   asynchronous request, data valid while high
//   pi_data     Pi -> FPGA   data bus, stable from before req rise until ack seen
//   fpga_ack    FPGA -> Pi   registered acknowledge
//   m_data      FPGA -> sink FIFO head byte
//   m_valid     FPGA -> sink FIFO non-empty
//   m_ready     sink -> FPGA sink can take m_data
// Stream handshake: a byte moves on every rising clk edge where m_valid and
// m_ready are both high; m_data is meaningful only while m_valid is high, and
// m_valid never depends combinationally on m_ready.
// Modports: slave = the receiver block, master = the Pi and the downstream sink.
interface pi_byte_receiver_if;
    import pi_link_pkg::*;

    logic                 pi_req_raw;
    logic [PI_DATA_W-1:0] pi_data;
    logic                 fpga_ack;
    logic [PI_DATA_W-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;

    modport slave (
        input  pi_req_raw, pi_data, m_ready,
        output fpga_ack, m_data, m_valid
    );

    modport master (
        output pi_req_raw, pi_data, m_ready,
        input  fpga_ack, m_data, m_valid
    );

endinterface

// File: rtl/pi_rx_fifo.sv
// pi_rx_fifo
// Synchronous first-word-fall-through FIFO.
//   clk, reset  clock, synchronous active-high reset (empties the FIFO)
//   push, wdata write request and data; ignored while full
//   pop         read request; ignored while empty
//   rdata       head entry, valid whenever empty is low
//   full, empty occupancy flags
//   level       current occupancy, 0..DEPTH
module pi_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra bit so that full and empty differ.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pi_byte_receiver.sv
// pi_byte_receiver
// Receives bytes from the Raspberry Pi 4-phase req/ack link, queues them in a
// FWFT FIFO and presents them downstream as a valid/ready stream. When the
// FIFO is full the request is held in STALL with acknowledge low.
//   clk, reset   system clock, synchronous active-high reset
//   link         Pi link and downstream stream (slave side)
//   fifo_level   FIFO occupancy
//   rx_count     bytes accepted, wraps at 16 bits
//   timeout_err  sticky: Pi held req too long after ack
//   err_clr      clears timeout_err (a simultaneous set wins)
//   state        current handshake FSM state, for debug
module pi_byte_receiver
    import pi_link_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                        clk,
    input  logic                        reset,
    pi_byte_receiver_if.slave           link,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [RX_CNT_W-1:0]         rx_count,
    output logic                        timeout_err,
    input  logic                        err_clr,
    output pi_state_e                   state
);

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    pi_state_e              state_q;
    logic                   ack_q;
    logic [31:0]            to_cnt;
    logic [RX_CNT_W-1:0]    rx_cnt_q;
    logic                   err_q;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;

    // Only the request line crosses domains; pi_data is guaranteed stable
    // by the time the synchronised request is seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], link.pi_req_raw};
        end
    end
    assign req_s = sync_q[SYNC_STAGES-1];

    // A byte is taken only on leaving IDLE/STALL, so each request pushes once.
    assign push = req_s & ~full & ((state_q == ST_IDLE) | (state_q == ST_STALL));
    assign pop  = ~empty & link.m_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            to_cnt   <= '0;
            rx_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            // Clear first so a timeout set later in this block overrides it.
            if (err_clr) err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (push) begin
                        state_q  <= ST_ACK;
                        ack_q    <= 1'b1;
                        to_cnt   <= '0;
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end else if (req_s) begin
                        state_q <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!req_s) begin
                        state_q <= ST_IDLE;
                    end else if (push) begin
                        state_q  <= ST_ACK;
                        ack_q    <= 1'b1;
                        to_cnt   <= '0;
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                ST_ACK: begin
                    if (!req_s) begin
                        state_q <= ST_IDLE;
                        ack_q   <= 1'b0;
                    end else if (TIMEOUT_CYCLES != 0 && to_cnt == TO_LAST) begin
                        state_q <= ST_RECOVER;
                        ack_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                ST_RECOVER: begin
                    if (!req_s) state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    pi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PI_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (link.pi_data),
        .pop   (pop),
        .rdata (link.m_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign link.fpga_ack = ack_q;
    assign link.m_valid  = ~empty;
    assign rx_count      = rx_cnt_q;
    assign timeout_err   = err_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pi_byte_receiver.sv
// tb_pi_byte_receiver
// Directed bench for pi_byte_receiver with FIFO_DEPTH=16, SYNC_STAGES=2,
// TIMEOUT_CYCLES=8. Sent bytes go into exp_q; popped stream bytes are
// compared against the queue head.
module tb_pi_byte_receiver;
    import pi_link_pkg::*;

    localparam int W = PI_DATA_W;

    logic        clk;
    logic        reset;
    logic        err_clr;
    logic [4:0]  fifo_level;
    logic [15:0] rx_count;
    logic        timeout_err;
    pi_state_e   dut_state;

    pi_byte_receiver_if bus ();

    pi_byte_receiver #(
        .FIFO_DEPTH     (16),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .link        (bus.slave),
        .fifo_level  (fifo_level),
        .rx_count    (rx_count),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .state       (dut_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_byte;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl, input string tag);
        int n = 0;
        while (bus.fpga_ack !== lvl && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.fpga_ack), 32'(lvl));
    endtask

    // driver: one complete 4-phase transfer
    task automatic send_byte(input logic [W-1:0] d, input string tag);
        bus.pi_data    = d;
        bus.pi_req_raw = 1'b1;
        exp_q.push_back(d);
        wait_ack(1'b1, {tag, "_ack_hi"});
        bus.pi_req_raw = 1'b0;
        wait_ack(1'b0, {tag, "_ack_lo"});
    endtask

    // scoreboard: drain the stream and compare against exp_q
    task automatic drain(input string tag);
        int n = 0;
        bus.m_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            if (bus.m_valid === 1'b1) begin
                exp_byte = exp_q.pop_front();
                chk({tag, "_data"}, 32'(bus.m_data), 32'(exp_byte));
            end
            tick();
            n++;
        end
        bus.m_ready = 1'b0;
        chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_lvl0"}, 32'(fifo_level), 32'd0);
        chk({tag, "_vld0"}, 32'(bus.m_valid), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        err_clr        = 1'b0;
        bus.pi_req_raw = 1'b0;
        bus.pi_data    = '0;
        bus.m_ready    = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_ack",   32'(bus.fpga_ack), 32'd0);
        chk("rst_valid", 32'(bus.m_valid),  32'd0);
        chk("rst_level", 32'(fifo_level),   32'd0);
        chk("rst_count", 32'(rx_count),     32'd0);
        chk("rst_err",   32'(timeout_err),  32'd0);
        chk("rst_state", 32'(dut_state),    32'(ST_IDLE));
        reset = 1'b0;
        tick();

        // single byte: ack rises 3 edges after req, falls 3 edges after drop
        bus.pi_data    = 8'hA5;
        bus.pi_req_raw = 1'b1;
        exp_q.push_back(8'hA5);
        tick(); tick();
        chk("one_ack_e2", 32'(bus.fpga_ack), 32'd0);
        tick();
        chk("one_ack_e3", 32'(bus.fpga_ack), 32'd1);
        chk("one_valid",  32'(bus.m_valid),  32'd1);
        chk("one_data",   32'(bus.m_data),   32'hA5);
        chk("one_count",  32'(rx_count),     32'd1);
        bus.pi_req_raw = 1'b0;
        tick(); tick();
        chk("one_fall_e2", 32'(bus.fpga_ack), 32'd1);
        tick();
        chk("one_fall_e3", 32'(bus.fpga_ack), 32'd0);
        drain("one");

        // back-pressure: 16 fill the FIFO, the 17th stalls
        for (int i = 0; i < 16; i++) send_byte(8'(i), "bp");
        chk("bp_level16", 32'(fifo_level), 32'd16);
        bus.pi_data    = 8'h10;
        bus.pi_req_raw = 1'b1;
        exp_q.push_back(8'h10);
        repeat (5) tick();
        chk("bp_stall_state", 32'(dut_state),    32'(ST_STALL));
        chk("bp_stall_ack",   32'(bus.fpga_ack), 32'd0);
        chk("bp_stall_level", 32'(fifo_level),   32'd16);
        bus.m_ready = 1'b1;
        exp_byte = exp_q.pop_front();
        chk("bp_pulse_data", 32'(bus.m_data), 32'(exp_byte));
        tick();
        bus.m_ready = 1'b0;
        chk("bp_after_pop_level", 32'(fifo_level), 32'd15);
        tick();
        chk("bp_push_ack",   32'(bus.fpga_ack), 32'd1);
        chk("bp_push_level", 32'(fifo_level),   32'd16);
        bus.pi_req_raw = 1'b0;
        wait_ack(1'b0, "bp_last_ack_lo");
        chk("bp_count", 32'(rx_count), 32'd18);
        drain("bp");

        // simultaneous pop and pending push at full
        for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), "sim");
        bus.pi_data    = 8'h5A;
        bus.pi_req_raw = 1'b1;
        exp_q.push_back(8'h5A);
        tick(); tick();
        bus.m_ready = 1'b1;
        exp_byte = exp_q.pop_front();
        chk("sim_pop_data", 32'(bus.m_data), 32'(exp_byte));
        tick();
        bus.m_ready = 1'b0;
        chk("sim_level15", 32'(fifo_level),   32'd15);
        chk("sim_ack0",    32'(bus.fpga_ack), 32'd0);
        chk("sim_stall",   32'(dut_state),    32'(ST_STALL));
        tick();
        chk("sim_level16", 32'(fifo_level),   32'd16);
        chk("sim_ack1",    32'(bus.fpga_ack), 32'd1);
        bus.pi_req_raw = 1'b0;
        wait_ack(1'b0, "sim_ack_lo");
        drain("sim");

        // reset mid-ACK with 3 bytes queued
        send_byte(8'h11, "rst");
        send_byte(8'h22, "rst");
        send_byte(8'h33, "rst");
        bus.pi_data    = 8'hC3;
        bus.pi_req_raw = 1'b1;
        wait_ack(1'b1, "rst_mid_ack");
        reset = 1'b1;
        tick();
        chk("rst_mid_ack0",  32'(bus.fpga_ack), 32'd0);
        chk("rst_mid_vld0",  32'(bus.m_valid),  32'd0);
        chk("rst_mid_lvl0",  32'(fifo_level),   32'd0);
        chk("rst_mid_cnt0",  32'(rx_count),     32'd0);
        chk("rst_mid_state", 32'(dut_state),    32'(ST_IDLE));
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'hC3);
        wait_ack(1'b1, "rst_dup_ack");
        chk("rst_dup_cnt", 32'(rx_count),   32'd1);
        chk("rst_dup_lvl", 32'(fifo_level), 32'd1);
        bus.pi_req_raw = 1'b0;
        wait_ack(1'b0, "rst_dup_ack_lo");
        drain("rst_dup");

        // rx_count wrap
        force dut.rx_cnt_q = 16'hFFFF;
        tick();
        release dut.rx_cnt_q;
        tick();
        chk("wrap_pre", 32'(rx_count), 32'hFFFF);
        send_byte(8'h77, "wrap");
        chk("wrap_zero", 32'(rx_count), 32'd0);
        drain("wrap");

        // timeout: ack high for 8 cycles, then RECOVER with error set
        bus.pi_data    = 8'h3C;
        bus.pi_req_raw = 1'b1;
        exp_q.push_back(8'h3C);
        repeat (3) tick();
        chk("to_ack_rise", 32'(bus.fpga_ack), 32'd1);
        repeat (7) tick();
        chk("to_ack_last", 32'(bus.fpga_ack), 32'd1);
        chk("to_err_pre",  32'(timeout_err),  32'd0);
        tick();
        chk("to_ack_drop", 32'(bus.fpga_ack), 32'd0);
        chk("to_err_set",  32'(timeout_err),  32'd1);
        chk("to_recover",  32'(dut_state),    32'(ST_RECOVER));
        bus.pi_req_raw = 1'b0;
        repeat (3) tick();
        chk("to_idle", 32'(dut_state), 32'(ST_IDLE));
        drain("to");

        // clear together with a new timeout: set wins
        bus.pi_data    = 8'h3D;
        bus.pi_req_raw = 1'b1;
        exp_q.push_back(8'h3D);
        repeat (10) tick();
        chk("to2_ack", 32'(bus.fpga_ack), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to2_ack_drop",  32'(bus.fpga_ack), 32'd0);
        chk("to2_set_wins",  32'(timeout_err),  32'd1);
        bus.pi_req_raw = 1'b0;
        repeat (3) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("to2_clear", 32'(timeout_err), 32'd0);
        drain("to2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pi_byte_receiver.md
# pi_byte_receiver

Consumes the Raspberry Pi parallel byte link and turns it into an on-chip stream. It sits directly behind the Pi-facing pins and owns the full 4-phase request/acknowledge exchange on the 8-bit data bus. Accepted bytes go into an internal FIFO and are presented to downstream logic as a valid/ready stream. When the FIFO is full, the block back-pressures the Pi by withholding acknowledge.

## Interface
Parameters:
- FIFO_DEPTH, 16, byte FIFO entries; power of two, ≥2
- SYNC_STAGES, 2, flops on pi_req_raw; ≥2
- TIMEOUT_CYCLES, 1000000, max cycles in ACK waiting for req low; 0 disables

Ports (reset reset, synchronous, active-high; clock clk):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pi_req_raw  in  1  asynchronous Pi request; data valid while high
- pi_data  in  8  Pi data bus; stable from before req rise until ack seen
- fpga_ack  out  1  registered acknowledge to Pi
- m_data  out  8  FIFO head byte (first-word fall-through)
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  downstream accepts m_data when m_valid & m_ready
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- rx_count  out  16  bytes accepted, wraps 0xFFFF→0
- timeout_err  out  1  sticky handshake timeout flag
- err_clr  in  1  clears timeout_err

## Operation
- pi_req_raw passes through SYNC_STAGES flops to give req_s. No other input is synchronised.
- pi_data is sampled only when req_s is high; the Pi protocol guarantees it is stable by then.
- FSM states and transitions:
  - IDLE: if req_s & !full, push pi_data, rx_count+1, go to ACK. If req_s & full, go to STALL.
  - STALL: fpga_ack stays low. When !full, push pi_data, rx_count+1, go to ACK. If req_s drops, go to IDLE with no push.
  - ACK: fpga_ack=1 and the timeout counter runs. If !req_s, go to IDLE. If the counter reaches TIMEOUT_CYCLES, set timeout_err and go to RECOVER.
  - RECOVER: fpga_ack=0. If !req_s, go to IDLE.
- Exactly one push per request. Only the first sample at the IDLE/STALL exit is stored.
- FIFO behaviour:
  - A push is blocked when full, even if a pop occurs in the same cycle.
  - A pop happens when m_valid & m_ready. A pop when empty is a no-op.
  - Simultaneous push and pop: level unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH. Level is the full-width difference.
- timeout_err:
  - Set by the timeout only, cleared by err_clr.
  - Set and clear in the same cycle: set wins.

## Timing
- Reset values: fpga_ack=0, m_valid=0, fifo_level=0, rx_count=0, timeout_err=0, state IDLE, FIFO empty, m_data don't-care.
- req rise to ack rise:
  - With pi_req_raw meeting setup before edge E, req_s is high after edge E+SYNC_STAGES-1.
  - The push and state→ACK happen at edge E+SYNC_STAGES.
  - fpga_ack is high after E+SYNC_STAGES, i.e. 3 edges at default.
- req fall to ack fall: same 3-edge latency.
- Push to m_valid: m_valid is high the cycle after the push edge (1-cycle latency). m_data is valid together with m_valid.
- fifo_level and rx_count update on the push/pop edge.
- Reset mid-handshake: state returns to IDLE, ack drops next edge, and FIFO contents are discarded. If req is still high after reset, the byte is captured again; the Pi software must tolerate the duplicate.
- Timeout count starts at 0 on ACK entry and increments each ACK cycle. The ACK→RECOVER move happens at the edge where count==TIMEOUT_CYCLES-1.

## Structure
- A shared package pi_link_pkg holds:
  - the state enum (IDLE, STALL, ACK, RECOVER)
  - the byte width constant PI_DATA_W=8
  - the rx_count width RX_CNT_W=16
- One sub-module, pi_rx_fifo: synchronous FWFT FIFO with parameters DEPTH and WIDTH, and ports push, wdata, pop, rdata, full, empty, level. The top contains the synchroniser, FSM, counters and error logic.

## Test plan
- Single byte: drive pi_data=0xA5, raise req, hold until ack → fpga_ack high 3 edges after req, m_data=0xA5, m_valid=1, rx_count=1. Drop req → ack low 3 edges later.
- Back-pressure: m_ready=0, send 17 bytes 0x00..0x10 with FIFO_DEPTH=16 → 16 acked, fifo_level=16. The 17th request stays in STALL with ack=0. Pulse m_ready one cycle → 0x10 is pushed, ack rises, and the drained order is 0x00..0x10.
- Simultaneous push/pop at full: level=16, m_ready=1 in the cycle a request is pending → pop occurs, push blocked that cycle, push next cycle, level returns to 16.
- Timeout: TIMEOUT_CYCLES=8, hold req high indefinitely → ack high 8 cycles then low, timeout_err=1. Drop req → IDLE. Pulse err_clr together with a new timeout → timeout_err stays 1. err_clr alone → 0.
- Reset mid-ACK: assert reset while ack=1 with 3 bytes queued → ack=0, m_valid=0, fifo_level=0, rx_count=0 after the edge. With req still high, one duplicate byte is captured after reset release.
- Wrap: preload rx_count via 65535 transfers (or a force) → next accepted byte gives rx_count=0.
